// File: rtl/seg_pkg.sv
// ============================================================================
// Module : seg_pkg
// Brief  : Shared types and seven-segment constants for sum_seg_display.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Segment order is {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [3:0] AN_UNITS  = 4'b1110;
    localparam logic [3:0] AN_TENS   = 4'b1101;

    function automatic logic [6:0] seg_enc(input logic [3:0] digit);
        logic [6:0] code;
        code = SEG_BLANK;
        if (digit < 4'd10) begin
            code = SEG_DIGIT[digit];
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sum_seg_display_bcd.sv
// ============================================================================
// Module : bin_to_bcd_seq
// Brief  : Sequential shift-add-3 binary to two-digit BCD converter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import seg_pkg::*;
#(
    parameter int SUM_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [SUM_W-1:0] bin_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic [3:0]       tens_o,
    output logic [3:0]       units_o
);

    localparam int BCD_W = 8;
    localparam int SR_W  = BCD_W + SUM_W;
    localparam int CNT_W = $clog2(SUM_W + 1);

    conv_state_e        state_q;
    logic [SR_W-1:0]    sr_q;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_shift_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [3:0]         tens_q;
    logic [3:0]         units_q;

    // Any nibble >= 5 would overflow past 9 after the shift, so pre-correct by 3
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[SR_W-1 -: 4] >= 4'd5) begin
            sr_adj[SR_W-1 -: 4] = sr_q[SR_W-1 -: 4] + 4'd3;
        end
        if (sr_q[SR_W-5 -: 4] >= 4'd5) begin
            sr_adj[SR_W-5 -: 4] = sr_q[SR_W-5 -: 4] + 4'd3;
        end
        sr_shift_d = {sr_adj[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sr_q    <= {{BCD_W{1'b0}}, bin_i};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_shift_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SUM_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    tens_q  <= sr_q[SR_W-1 -: 4];
                    units_q <= sr_q[SR_W-5 -: 4];
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = busy_q;
    assign tens_o  = tens_q;
    assign units_o = units_q;

endmodule

`default_nettype wire

// File: rtl/sum_seg_display.sv
// ============================================================================
// Module : sum_seg_display
// Brief  : Shows a 5-bit adder result as two decimal digits on a muxed display.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sum_seg_display
    import seg_pkg::*;
#(
    parameter int SUM_W       = 5,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] sum,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             busy
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [SUM_W-1:0] sum_meta_q;
    logic [SUM_W-1:0] sum_s_q;
    logic [SUM_W-1:0] held_q;
    logic             conv_ready;
    logic             conv_start;
    logic [3:0]       tens;
    logic [3:0]       units;
    logic [RC_W-1:0]  refresh_q;
    logic             digit_sel_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;

    // Bits may resolve on different cycles; the next conversion settles it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_meta_q <= '0;
            sum_s_q    <= '0;
        end else begin
            sum_meta_q <= sum;
            sum_s_q    <= sum_meta_q;
        end
    end

    assign conv_start = conv_ready && (sum_s_q != held_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
        end else if (conv_start) begin
            held_q <= sum_s_q;
        end
    end

    bin_to_bcd_seq #(
        .SUM_W   (SUM_W)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bin_i   (sum_s_q),
        .ready_o (conv_ready),
        .busy_o  (busy),
        .tens_o  (tens),
        .units_o (units)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q   <= '0;
            digit_sel_q <= 1'b0;
        end else if (refresh_q == RC_W'(REFRESH_DIV - 1)) begin
            refresh_q   <= '0;
            digit_sel_q <= ~digit_sel_q;
        end else begin
            refresh_q   <= refresh_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else if (!digit_sel_q) begin
            an_q  <= AN_UNITS;
            seg_q <= seg_enc(units);
        end else if (tens != 4'd0) begin
            an_q  <= AN_TENS;
            seg_q <= seg_enc(tens);
        end else begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_sum_seg_display.sv
// ============================================================================
// Module : tb_sum_seg_display
// Brief  : Directed self-checking bench for sum_seg_display (REFRESH_DIV=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sum_seg_display;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] sum   = 5'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int checks = 0;
    int passes = 0;

    sum_seg_display #(
        .SUM_W       (5),
        .REFRESH_DIV (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sum   (sum),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full 8-cycle frame: units slot, tens slot (or blank), no overlap, no busy
    task automatic scan(input string tag, input logic [6:0] u_seg,
                        input logic [6:0] t_seg, input bit t_on);
        logic [6:0] u_seen;
        logic [6:0] t_seen;
        int u_hits, t_hits, b_hits, multi, bz;
        u_seen = 'x;
        t_seen = 'x;
        u_hits = 0; t_hits = 0; b_hits = 0; multi = 0; bz = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ($countones(~an) > 1) multi++;
            if (busy) bz++;
            case (an)
                4'b1110: begin u_hits++; u_seen = seg; end
                4'b1101: begin t_hits++; t_seen = seg; end
                4'b1111: if (seg === 7'b1111111) b_hits++;
                default: ;
            endcase
        end
        chk({tag, "_units_seg"}, u_seen, u_seg);
        chk({tag, "_units_slots"}, u_hits, 4);
        chk({tag, "_multi_low"}, multi, 0);
        chk({tag, "_busy"}, bz, 0);
        chk({tag, "_tens_slots"}, t_hits, t_on ? 4 : 0);
        if (t_on) chk({tag, "_tens_seg"}, t_seen, t_seg);
        else      chk({tag, "_blank_slots"}, b_hits, 4);
    endtask

    task automatic wait_conv(output int cycles, output int hi);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        hi     = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (busy) begin
                seen = 1'b1;
                hi++;
            end else if (seen) begin
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, hi, n, run, ntr, multi;
        bit seen7, first_busy;
        logic [3:0] prev;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_dp", dp, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        scan("zero", 7'b1000000, 7'b1111111, 1'b0);

        sum = 5'd31;
        wait_conv(lat, hi);
        chk("s31_latency", lat, 9);
        chk("s31_busy_len", hi, 6);
        scan("s31", 7'b1111001, 7'b0110000, 1'b1);

        prev  = an;
        run   = 0;
        ntr   = 0;
        multi = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if ($countones(~an) > 1) multi++;
            if (an != prev) begin
                if (ntr > 0) chk("refresh_run", run, 4);
                ntr++;
                run  = 1;
                prev = an;
            end else begin
                run++;
            end
        end
        chk("refresh_transitions", ntr >= 5, 1'b1);
        chk("refresh_multi_low", multi, 0);
        dp_chk: chk("dp_const", dp, 1'b1);

        sum = 5'd10;
        wait_conv(lat, hi);
        chk("s10_latency", lat, 9);
        scan("s10", 7'b1000000, 7'b1111001, 1'b1);

        sum = 5'd7;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (busy) break;
        end
        chk("s7_rise", n, 3);
        repeat (2) @(negedge clk);
        sum = 5'd19;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (!busy) break;
        end
        chk("s7_fall", n, 4);
        seen7      = 1'b0;
        first_busy = 1'b0;
        hi         = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) first_busy = busy;
            if (an == 4'b1110 && seg == 7'b1111000) seen7 = 1'b1;
            if (busy) hi++;
            else if (hi > 0) break;
        end
        chk("s19_restart", first_busy, 1'b1);
        chk("s7_shown", seen7, 1'b1);
        chk("s19_busy_len", hi, 6);
        scan("s19", 7'b0010000, 7'b1111001, 1'b1);

        sum = 5'd25;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_an", an, 4'b1111);
        chk("midrst_seg", seg, 7'b1111111);
        chk("midrst_busy", busy, 1'b0);
        sum = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan("after_rst", 7'b1000000, 7'b1111111, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
